vend_txn_ctrl: RTL and testbench

//  Transaction controller for the coin vending path. It accumulates coin credit, accepts a
//  two-item product selection and drives a dispense handshake to the product motor.
//  It returns unspent credit as change pulses on cancel, on timeout or after a vend.
//  It sits between the coin acceptor / keypad inputs and the dispense and change mechanisms.

---
 rtl/vend_txn_if.sv | 32 +++
 rtl/vend_txn_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vend_txn_if.sv
// Handshake and status bundle between the coin/keypad side and the vend
// transaction controller. The master drives coins, selections, cancel and the
// dispense acknowledge; the slave (controller) drives dispense, change and status.
interface vend_txn_if #(
  parameter int CREDIT_W = 4
) ();

  logic                coin_5;
  logic                coin_10;
  logic                sel_valid;
  logic                sel_item;
  logic                cancel;
  logic                disp_ack;
  logic                disp_req;
  logic                disp_item;
  logic                chg_pulse;
  logic                coin_reject;
  logic                sel_nak;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_5, coin_10, sel_valid, sel_item, cancel, disp_ack,
    input  disp_req, disp_item, chg_pulse, coin_reject, sel_nak, credit, busy
  );

  modport slave (
    input  coin_5, coin_10, sel_valid, sel_item, cancel, disp_ack,
    output disp_req, disp_item, chg_pulse, coin_reject, sel_nak, credit, busy
  );

endinterface

// File: rtl/vend_txn_ctrl.sv
// Vend transaction controller: accumulates coin credit, accepts a two-item
// selection, runs the dispense handshake and pays back unspent credit as
// single-coin change pulses. Every output is a register.
module vend_txn_ctrl #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 8,
  parameter int PRICE0     = 3,
  parameter int PRICE1     = 4,
  parameter int TIMEOUT    = 1000,
  parameter int TO_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  vend_txn_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  // Two extra bits so credit + coin value can never wrap during the fit check.
  localparam int SUM_W = CREDIT_W + 2;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              state_q, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_n;
  logic                disp_req_q, disp_req_n;
  logic                disp_item_q, disp_item_n;
  logic                chg_q, chg_n;
  logic                rej_q, rej_n;
  logic                nak_q, nak_n;
  logic                busy_q, busy_n;

  logic                coin_any;
  logic [1:0]          coin_val;
  logic [CREDIT_W-1:0] price;
  logic                idle_tick;

  // Coin value in LSBs: coin_5 = 1, coin_10 = 2, both = 3.
  function automatic logic [1:0] coin_value(input logic c5, input logic c10);
    return {c10, 1'b0} + {1'b0, c5};
  endfunction

  // True when the coin can be taken whole without exceeding the credit ceiling.
  function automatic logic coin_fits(input logic [CREDIT_W-1:0] cur,
                                     input logic [1:0]          val);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cur) + SUM_W'(val);
    return sum <= SUM_W'(MAX_CREDIT);
  endfunction

  function automatic logic [CREDIT_W-1:0] price_of(input logic item);
    return item ? CREDIT_W'(PRICE1) : CREDIT_W'(PRICE0);
  endfunction

  assign coin_any = bus.coin_5 | bus.coin_10;
  assign coin_val = coin_value(bus.coin_5, bus.coin_10);
  assign price    = price_of(bus.sel_item);

  // Next-state and next-output decode for the transaction FSM.
  always_comb begin
    state_n     = state_q;
    credit_n    = credit_q;
    to_cnt_n    = to_cnt_q;
    disp_req_n  = disp_req_q;
    disp_item_n = disp_item_q;
    chg_n       = 1'b0;
    rej_n       = 1'b0;
    nak_n       = 1'b0;
    idle_tick   = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_n = '0;
        nak_n    = bus.sel_valid;
        if (coin_any) begin
          if (coin_fits(credit_q, coin_val)) begin
            credit_n = credit_q + CREDIT_W'(coin_val);
            state_n  = CREDIT;
          end else begin
            rej_n = 1'b1;
          end
        end
      end

      CREDIT: begin
        // Priority cancel > selection > coin; a coin losing arbitration is returned.
        if (bus.cancel) begin
          rej_n    = coin_any;
          to_cnt_n = '0;
          state_n  = CHANGE;
        end else if (bus.sel_valid) begin
          rej_n = coin_any;
          if (credit_q >= price) begin
            credit_n    = credit_q - price;
            disp_req_n  = 1'b1;
            disp_item_n = bus.sel_item;
            to_cnt_n    = '0;
            state_n     = DISPENSE;
          end else begin
            nak_n     = 1'b1;
            idle_tick = 1'b1;
          end
        end else if (coin_any && coin_fits(credit_q, coin_val)) begin
          credit_n = credit_q + CREDIT_W'(coin_val);
          to_cnt_n = '0;
        end else begin
          rej_n     = coin_any;
          idle_tick = 1'b1;
        end

        // No accepted coin this cycle: advance the inactivity timer, refund on expiry.
        if (idle_tick) begin
          if (to_cnt_q == TO_LAST) begin
            to_cnt_n = '0;
            state_n  = CHANGE;
          end else begin
            to_cnt_n = to_cnt_q + TO_W'(1);
          end
        end
      end

      DISPENSE: begin
        rej_n = coin_any;
        nak_n = bus.sel_valid;
        if (bus.disp_ack) begin
          disp_req_n = 1'b0;
          state_n    = (credit_q != '0) ? CHANGE : IDLE;
        end
      end

      CHANGE: begin
        rej_n = coin_any;
        nak_n = bus.sel_valid;
        // The previous pulse register doubles as the high/low phase bit.
        if (credit_q == '0) begin
          state_n = IDLE;
        end else if (!chg_q) begin
          chg_n    = 1'b1;
          credit_n = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  // State, credit, timer and registered outputs; reset aborts any vend without change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      to_cnt_q    <= '0;
      disp_req_q  <= 1'b0;
      disp_item_q <= 1'b0;
      chg_q       <= 1'b0;
      rej_q       <= 1'b0;
      nak_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      credit_q    <= credit_n;
      to_cnt_q    <= to_cnt_n;
      disp_req_q  <= disp_req_n;
      disp_item_q <= disp_item_n;
      chg_q       <= chg_n;
      rej_q       <= rej_n;
      nak_q       <= nak_n;
      busy_q      <= busy_n;
    end
  end

  assign bus.disp_req    = disp_req_q;
  assign bus.disp_item   = disp_item_q;
  assign bus.chg_pulse   = chg_q;
  assign bus.coin_reject = rej_q;
  assign bus.sel_nak     = nak_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: a per-cycle vector table plus hand-written
// sequences for the inactivity timeout and a reset in the middle of a vend.
module tb_vend_txn_ctrl;

  localparam int CREDIT_W = 4;
  localparam int TIMEOUT  = 1000;

  // Input bits {coin_5, coin_10, sel_valid, sel_item, cancel, disp_ack}
  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] C5   = 6'b100000;
  localparam logic [5:0] C10  = 6'b010000;
  localparam logic [5:0] SV   = 6'b001000;
  localparam logic [5:0] SI   = 6'b000100;
  localparam logic [5:0] CN   = 6'b000010;
  localparam logic [5:0] ACK  = 6'b000001;

  // Output flag bits {disp_req, disp_item, chg_pulse, coin_reject, sel_nak, busy}
  localparam logic [5:0] REQ = 6'b100000;
  localparam logic [5:0] ITM = 6'b010000;
  localparam logic [5:0] CHG = 6'b001000;
  localparam logic [5:0] REJ = 6'b000100;
  localparam logic [5:0] NAK = 6'b000010;
  localparam logic [5:0] BSY = 6'b000001;

  typedef struct {
    logic [5:0]          in;
    logic [5:0]          ef;
    logic [CREDIT_W-1:0] ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vend_txn_if #(.CREDIT_W(CREDIT_W)) intf ();

  vend_txn_ctrl #(
    .CREDIT_W  (CREDIT_W),
    .MAX_CREDIT(8),
    .PRICE0    (3),
    .PRICE1    (4),
    .TIMEOUT   (TIMEOUT),
    .TO_W      (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (intf)
  );

  function automatic vec_t mk(input logic [5:0] in, input logic [5:0] ef, input int ec);
    vec_t v;
    v.in = in;
    v.ef = ef;
    v.ec = CREDIT_W'(ec);
    return v;
  endfunction

  function automatic logic [5:0] flags();
    return {intf.disp_req, intf.disp_item, intf.chg_pulse,
            intf.coin_reject, intf.sel_nak, intf.busy};
  endfunction

  task automatic drive(input logic [5:0] in);
    {intf.coin_5, intf.coin_10, intf.sel_valid,
     intf.sel_item, intf.cancel, intf.disp_ack} = in;
  endtask

  // Apply inputs on the falling edge, sample outputs just after the rising edge.
  task automatic step(input logic [5:0] in);
    @(negedge clk);
    drive(in);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [5:0] ef, input logic [CREDIT_W-1:0] ec);
    n_checks++;
    if (flags() === ef && intf.credit === ec) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got flags(req,item,chg,rej,nak,busy)=%b credit=%0d, want flags=%b credit=%0d",
               name, flags(), intf.credit, ef, ec);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, got, want);
  endtask

  initial begin
    int pulses;

    // Scenario 1: 10 + 5 buys item 0 exactly, no change.
    tbl.push_back(mk(C10,      BSY,           2));
    tbl.push_back(mk(C5,       BSY,           3));
    tbl.push_back(mk(SV,       REQ|BSY,       0));
    tbl.push_back(mk(NONE,     REQ|BSY,       0));
    tbl.push_back(mk(ACK,      6'b0,          0));
    tbl.push_back(mk(NONE,     6'b0,          0));
    // Scenario 2: 30 units, item 1, two change pulses on alternate cycles.
    tbl.push_back(mk(C10,      BSY,           2));
    tbl.push_back(mk(C10,      BSY,           4));
    tbl.push_back(mk(C10,      BSY,           6));
    tbl.push_back(mk(SV|SI,    REQ|ITM|BSY,   2));
    tbl.push_back(mk(ACK,      ITM|BSY,       2));
    tbl.push_back(mk(NONE,     ITM|CHG|BSY,   1));
    tbl.push_back(mk(NONE,     ITM|BSY,       1));
    tbl.push_back(mk(NONE,     ITM|CHG,       0));
    tbl.push_back(mk(NONE,     ITM,           0));
    // Scenario 3: insufficient credit refused, then cancel refunds.
    tbl.push_back(mk(C10,      ITM|BSY,       2));
    tbl.push_back(mk(SV,       ITM|NAK|BSY,   2));
    tbl.push_back(mk(CN,       ITM|BSY,       2));
    tbl.push_back(mk(NONE,     ITM|CHG|BSY,   1));
    tbl.push_back(mk(NONE,     ITM|BSY,       1));
    tbl.push_back(mk(NONE,     ITM|CHG,       0));
    // Scenario 4: ceiling rejection, fill to 8, coin during dispense and change.
    tbl.push_back(mk(C10,      ITM|BSY,       2));
    tbl.push_back(mk(C10,      ITM|BSY,       4));
    tbl.push_back(mk(C10,      ITM|BSY,       6));
    tbl.push_back(mk(C5,       ITM|BSY,       7));
    tbl.push_back(mk(C10,      ITM|REJ|BSY,   7));
    tbl.push_back(mk(C5,       ITM|BSY,       8));
    tbl.push_back(mk(SV|SI,    REQ|ITM|BSY,   4));
    tbl.push_back(mk(C5,       REQ|ITM|REJ|BSY, 4));
    tbl.push_back(mk(ACK,      ITM|BSY,       4));
    tbl.push_back(mk(NONE,     ITM|CHG|BSY,   3));
    tbl.push_back(mk(C10,      ITM|REJ|BSY,   3));
    tbl.push_back(mk(NONE,     ITM|CHG|BSY,   2));
    tbl.push_back(mk(SV,       ITM|NAK|BSY,   2));
    tbl.push_back(mk(NONE,     ITM|CHG|BSY,   1));
    tbl.push_back(mk(CN,       ITM|BSY,       1));
    tbl.push_back(mk(NONE,     ITM|CHG,       0));
    // IDLE corner cases, double coin, coin with selection, cancel beats selection.
    tbl.push_back(mk(SV,       ITM|NAK,       0));
    tbl.push_back(mk(CN|ACK,   ITM,           0));
    tbl.push_back(mk(C5|C10,   ITM|BSY,       3));
    tbl.push_back(mk(C5|SV|SI, ITM|REJ|NAK|BSY, 3));
    tbl.push_back(mk(C5|C10,   ITM|BSY,       6));
    tbl.push_back(mk(C5|C10,   ITM|REJ|BSY,   6));
    tbl.push_back(mk(C5|CN|SV, ITM|REJ|BSY,   6));
    for (int k = 5; k >= 0; k--) begin
      tbl.push_back(mk(NONE, ITM|CHG|((k != 0) ? BSY : 6'b0), k));
      if (k != 0) tbl.push_back(mk(NONE, ITM|BSY, k));
    end

    // Reset state
    reset = 1'b1;
    drive(NONE);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 6'b0, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].in);
      check($sformatf("vec%0d", i), tbl[i].ef, tbl[i].ec);
    end

    // Inactivity timeout refunds a single coin.
    step(C5);
    check("to_load", ITM|BSY, 1);
    pulses = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step(NONE);
      if (intf.chg_pulse) pulses++;
    end
    check_int("to_no_early_pulse", pulses, 0);
    check("to_in_change", ITM|BSY, 1);
    step(NONE);
    check("to_pulse", ITM|CHG, 0);
    step(NONE);
    check("to_idle", ITM, 0);

    // Reset while disp_req is high aborts the vend with no change.
    step(C5|C10);
    check("rst_load", ITM|BSY, 3);
    step(SV);
    check("rst_vend", REQ|BSY, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(NONE);
    @(posedge clk);
    #1;
    check("rst_abort", 6'b0, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(NONE);
      if (intf.chg_pulse || intf.busy || intf.disp_req) pulses++;
    end
    check_int("rst_quiet", pulses, 0);
    check("rst_final", 6'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
